// File: rtl/arp_pkg.sv
// Shared constants, state encoding and frame payload type for the ARP sequencing controller.
package arp_pkg;

    localparam int unsigned MAC_W   = 48;
    localparam int unsigned IP_W    = 32;
    localparam int unsigned CNT_W   = 32;
    localparam int unsigned RETRY_W = 4;

    localparam logic [MAC_W-1:0] ARP_BCAST_MAC = 48'hff_ff_ff_ff_ff_ff;
    localparam logic             ARP_OP_REQ    = 1'b0;
    localparam logic             ARP_OP_RPL    = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_REQ_TX     = 2'd1,
        ST_WAIT_REPLY = 2'd2,
        ST_RPL_TX     = 2'd3
    } arp_state_t;

    typedef struct packed {
        logic             op;
        logic [MAC_W-1:0] mac;
        logic [IP_W-1:0]  ip;
    } arp_frame_t;

endpackage

// File: rtl/arp_ctrl_if.sv
// User-port bundle between the ARP sequencing controller (master) and the ARP rx/tx engine (slave).
interface arp_ctrl_if;
    import arp_pkg::*;

    logic             i_arp_rx_done;
    logic             i_arp_rx_type;
    logic [MAC_W-1:0] i_arp_srcmac_addr;
    logic [IP_W-1:0]  i_arp_srcip_addr;
    logic             o_arp_tx_en;
    logic             o_arp_tx_type;
    logic [MAC_W-1:0] o_arp_desmac_addr;
    logic [IP_W-1:0]  o_arp_desip_addr;
    logic             i_arp_tx_done;

    modport master (
        input  i_arp_rx_done, i_arp_rx_type, i_arp_srcmac_addr, i_arp_srcip_addr, i_arp_tx_done,
        output o_arp_tx_en, o_arp_tx_type, o_arp_desmac_addr, o_arp_desip_addr
    );

    modport slave (
        output i_arp_rx_done, i_arp_rx_type, i_arp_srcmac_addr, i_arp_srcip_addr, i_arp_tx_done,
        input  o_arp_tx_en, o_arp_tx_type, o_arp_desmac_addr, o_arp_desip_addr
    );

endinterface

// File: rtl/arp_retry_timer.sv
// Reply-wait timer: clearable, freezes when not incremented, flags the last cycle of the wait window.
module arp_retry_timer
    import arp_pkg::*;
#(
    parameter int unsigned RETRY_CYCLES = 125_000_000
)(
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clr,
    input  logic i_inc,
    output logic o_expire_c
);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_inc) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign o_expire_c = (r_count == CNT_W'(RETRY_CYCLES - 1));

endmodule

// File: rtl/arp_ctrl.sv
// ARP sequencing controller: answers requests for the board, resolves one peer IP with timed
// broadcast retries, and caches the learned peer MAC/IP.
module arp_ctrl
    import arp_pkg::*;
#(
    parameter int unsigned RETRY_CYCLES = 125_000_000,
    parameter int unsigned MAX_RETRY    = 3
)(
    input  logic             i_gmii_tx_clk,
    input  logic             i_rst_n,
    arp_ctrl_if.master       arp_bus,
    input  logic             i_resolve_req,
    input  logic [IP_W-1:0]  i_resolve_ip,
    output logic             o_busy,
    output logic             o_peer_valid,
    output logic [MAC_W-1:0] o_peer_mac,
    output logic [IP_W-1:0]  o_peer_ip,
    output logic             o_resolve_done,
    output logic             o_resolve_fail
);

    arp_state_t         r_state,     w_state_nxt;
    logic               r_resolving, w_resolving_nxt;
    logic [RETRY_W-1:0] r_retry,     w_retry_nxt;
    logic               r_pend_vld,  w_pend_vld_nxt;
    arp_frame_t         r_pend,      w_pend_nxt;
    logic               r_tx_en,     w_tx_en_nxt;
    arp_frame_t         r_tx,        w_tx_nxt;
    logic               r_peer_vld,  w_peer_vld_nxt;
    logic [MAC_W-1:0]   r_peer_mac,  w_peer_mac_nxt;
    logic [IP_W-1:0]    r_peer_ip,   w_peer_ip_nxt;
    logic               r_done,      w_done_nxt;
    logic               r_fail,      w_fail_nxt;
    logic               r_busy,      w_busy_nxt;
    logic               w_tmr_clr, w_tmr_inc, w_expire;
    logic               w_rx_req, w_cache_hit, w_reply_hit;

    arp_retry_timer #(.RETRY_CYCLES(RETRY_CYCLES)) u_timer (
        .i_clk      (i_gmii_tx_clk),
        .i_rst_n    (i_rst_n),
        .i_clr      (w_tmr_clr),
        .i_inc      (w_tmr_inc),
        .o_expire_c (w_expire)
    );

    assign w_rx_req    = arp_bus.i_arp_rx_done && (arp_bus.i_arp_rx_type == ARP_OP_REQ);
    assign w_cache_hit = arp_bus.i_arp_rx_done && (arp_bus.i_arp_srcip_addr == r_peer_ip)
                         && (r_resolving || r_peer_vld);
    // A cache already filled by a request frame from the peer counts as a reply.
    assign w_reply_hit = r_peer_vld || (arp_bus.i_arp_rx_done && (arp_bus.i_arp_rx_type == ARP_OP_RPL)
                         && (arp_bus.i_arp_srcip_addr == r_peer_ip));

    always_ff @(posedge i_gmii_tx_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= ST_IDLE;
            r_resolving <= 1'b0;
            r_retry     <= '0;
            r_pend_vld  <= 1'b0;
            r_pend      <= '0;
            r_tx_en     <= 1'b0;
            r_tx        <= '0;
            r_peer_vld  <= 1'b0;
            r_peer_mac  <= '0;
            r_peer_ip   <= '0;
            r_done      <= 1'b0;
            r_fail      <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_resolving <= w_resolving_nxt;
            r_retry     <= w_retry_nxt;
            r_pend_vld  <= w_pend_vld_nxt;
            r_pend      <= w_pend_nxt;
            r_tx_en     <= w_tx_en_nxt;
            r_tx        <= w_tx_nxt;
            r_peer_vld  <= w_peer_vld_nxt;
            r_peer_mac  <= w_peer_mac_nxt;
            r_peer_ip   <= w_peer_ip_nxt;
            r_done      <= w_done_nxt;
            r_fail      <= w_fail_nxt;
            r_busy      <= w_busy_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_resolving_nxt = r_resolving;
        w_retry_nxt     = r_retry;
        w_pend_vld_nxt  = r_pend_vld;
        w_pend_nxt      = r_pend;
        w_tx_en_nxt     = 1'b0;
        w_tx_nxt        = r_tx;
        w_peer_vld_nxt  = r_peer_vld;
        w_peer_mac_nxt  = r_peer_mac;
        w_peer_ip_nxt   = r_peer_ip;
        w_done_nxt      = 1'b0;
        w_fail_nxt      = 1'b0;
        w_tmr_clr       = 1'b0;
        w_tmr_inc       = 1'b0;

        if (w_cache_hit) begin
            w_peer_mac_nxt = arp_bus.i_arp_srcmac_addr;
            w_peer_vld_nxt = 1'b1;
        end

        case (r_state)
            ST_IDLE: begin
                if (r_pend_vld) begin
                    w_state_nxt    = ST_RPL_TX;
                    w_tx_en_nxt    = 1'b1;
                    w_tx_nxt       = r_pend;
                    w_pend_vld_nxt = 1'b0;
                end else if (i_resolve_req) begin
                    w_state_nxt     = ST_REQ_TX;
                    w_peer_ip_nxt   = i_resolve_ip;
                    w_peer_vld_nxt  = 1'b0;
                    w_retry_nxt     = '0;
                    w_resolving_nxt = 1'b1;
                    w_tx_en_nxt     = 1'b1;
                    w_tx_nxt        = '{op: ARP_OP_REQ, mac: ARP_BCAST_MAC, ip: i_resolve_ip};
                end
            end
            ST_REQ_TX: begin
                if (arp_bus.i_arp_tx_done) begin
                    w_tmr_clr   = 1'b1;
                    w_state_nxt = ST_WAIT_REPLY;
                end
            end
            ST_WAIT_REPLY: begin
                if (w_reply_hit) begin
                    w_done_nxt      = 1'b1;
                    w_resolving_nxt = 1'b0;
                    w_state_nxt     = ST_IDLE;
                end else if (r_pend_vld) begin
                    // Timer holds its value while the reply is out.
                    w_state_nxt    = ST_RPL_TX;
                    w_tx_en_nxt    = 1'b1;
                    w_tx_nxt       = r_pend;
                    w_pend_vld_nxt = 1'b0;
                end else if (w_expire) begin
                    if (r_retry < RETRY_W'(MAX_RETRY)) begin
                        w_retry_nxt = r_retry + RETRY_W'(1);
                        w_state_nxt = ST_REQ_TX;
                        w_tx_en_nxt = 1'b1;
                        w_tx_nxt    = '{op: ARP_OP_REQ, mac: ARP_BCAST_MAC, ip: r_peer_ip};
                    end else begin
                        w_fail_nxt      = 1'b1;
                        w_resolving_nxt = 1'b0;
                        w_peer_vld_nxt  = 1'b0;
                        w_state_nxt     = ST_IDLE;
                    end
                end else begin
                    w_tmr_inc = 1'b1;
                end
            end
            ST_RPL_TX: begin
                if (arp_bus.i_arp_tx_done) begin
                    w_state_nxt = r_resolving ? ST_WAIT_REPLY : ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase

        // Newest request wins; a same-cycle issue of the old one still re-arms the pending flag.
        if (w_rx_req) begin
            w_pend_vld_nxt = 1'b1;
            w_pend_nxt     = '{op: ARP_OP_RPL, mac: arp_bus.i_arp_srcmac_addr, ip: arp_bus.i_arp_srcip_addr};
        end

        w_busy_nxt = (w_state_nxt != ST_IDLE) || w_pend_vld_nxt;
    end

    assign arp_bus.o_arp_tx_en       = r_tx_en;
    assign arp_bus.o_arp_tx_type     = r_tx.op;
    assign arp_bus.o_arp_desmac_addr = r_tx.mac;
    assign arp_bus.o_arp_desip_addr  = r_tx.ip;
    assign o_busy                    = r_busy;
    assign o_peer_valid              = r_peer_vld;
    assign o_peer_mac                = r_peer_mac;
    assign o_peer_ip                 = r_peer_ip;
    assign o_resolve_done            = r_done;
    assign o_resolve_fail            = r_fail;

endmodule

// File: tb/tb_arp_ctrl.sv
// Self-checking bench for arp_ctrl: behavioural ARP engine, frame log and scenario-level expectations.
`timescale 1ns/1ps
module tb_arp_ctrl;
    import arp_pkg::*;

    localparam int unsigned R    = 600;
    localparam int unsigned MAXR = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        resolve_req;
    logic [31:0] resolve_ip;
    logic        busy, peer_valid, resolve_done, resolve_fail;
    logic [47:0] peer_mac;
    logic [31:0] peer_ip;

    arp_ctrl_if arp ();

    arp_ctrl #(.RETRY_CYCLES(R), .MAX_RETRY(MAXR)) dut (
        .i_gmii_tx_clk  (clk),
        .i_rst_n        (rst_n),
        .arp_bus        (arp.master),
        .i_resolve_req  (resolve_req),
        .i_resolve_ip   (resolve_ip),
        .o_busy         (busy),
        .o_peer_valid   (peer_valid),
        .o_peer_mac     (peer_mac),
        .o_peer_ip      (peer_ip),
        .o_resolve_done (resolve_done),
        .o_resolve_fail (resolve_fail)
    );

    always #4 clk = ~clk;

    typedef struct {
        int          cyc;
        logic        op;
        logic [47:0] mac;
        logic [31:0] ip;
    } frm_t;

    frm_t frames[$];
    int   dones[$];
    int   cyc = 0;
    int   n_done = 0, n_fail = 0, fail_cyc = 0;
    int   n_checks = 0, n_errors = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (resolve_done) n_done++;
        if (resolve_fail) begin
            n_fail++;
            fail_cyc = cyc;
        end
    end

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Engine model: logs every transmit start, answers with tx_done after a random latency.
    initial begin
        int  lat;
        bit  abort;
        arp.i_arp_tx_done = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n && arp.o_arp_tx_en) begin
                frames.push_back('{cyc, arp.o_arp_tx_type, arp.o_arp_desmac_addr, arp.o_arp_desip_addr});
                lat   = $urandom_range(6, 12);
                abort = 1'b0;
                repeat (lat) begin
                    @(posedge clk);
                    if (!rst_n) abort = 1'b1;
                end
                #1;
                if (abort || !rst_n) begin
                    dones.push_back(-1);
                end else begin
                    arp.i_arp_tx_done = 1'b1;
                    dones.push_back(cyc);
                    @(posedge clk); #1;
                    arp.i_arp_tx_done = 1'b0;
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_rx(input logic op, input logic [47:0] mac, input logic [31:0] ip, output int c);
        @(posedge clk); #1;
        arp.i_arp_rx_done     = 1'b1;
        arp.i_arp_rx_type     = op;
        arp.i_arp_srcmac_addr = mac;
        arp.i_arp_srcip_addr  = ip;
        c = cyc;
        @(posedge clk); #1;
        arp.i_arp_rx_done = 1'b0;
    endtask

    task automatic resolve(input logic [31:0] ip, output int c);
        @(posedge clk); #1;
        resolve_req = 1'b1;
        resolve_ip  = ip;
        c = cyc;
        @(posedge clk); #1;
        resolve_req = 1'b0;
    endtask

    task automatic wait_frames(input int n, input int budget, input string tag);
        int b = budget;
        while (frames.size() < n && b > 0) begin
            @(posedge clk); #1;
            b--;
        end
        chk(tag, 64'(frames.size() >= n), 64'd1);
    endtask

    task automatic wait_dones(input int n, input int budget, input string tag);
        int b = budget;
        while (dones.size() < n && b > 0) begin
            @(posedge clk); #1;
            b--;
        end
        chk(tag, 64'(dones.size() >= n), 64'd1);
    endtask

    task automatic wait_idle(input int budget, input string tag);
        int b = budget;
        while (busy && b > 0) begin
            @(posedge clk); #1;
            b--;
        end
        chk(tag, 64'(busy), 64'd0);
    endtask

    task automatic chk_frame(input string tag, input int idx, input int exp_cyc, input logic op,
                             input logic [47:0] mac, input logic [31:0] ip);
        if (frames.size() > idx) begin
            chk({tag, "_cyc"}, 64'(frames[idx].cyc), 64'(exp_cyc));
            chk({tag, "_op"},  64'(frames[idx].op),  64'(op));
            chk({tag, "_mac"}, 64'(frames[idx].mac), 64'(mac));
            chk({tag, "_ip"},  64'(frames[idx].ip),  64'(ip));
        end
    endtask

    initial begin
        #(8 * 60000);
        $display("FAIL watchdog: run still going at cycle %0d, required finish", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int          c, c2, n, d, t, k, base, d0, f0, b;
        logic [47:0] mac, mac2, pmac;
        logic [31:0] ip, ip2, pip;

        resolve_req           = 1'b0;
        resolve_ip            = '0;
        arp.i_arp_rx_done     = 1'b0;
        arp.i_arp_rx_type     = 1'b0;
        arp.i_arp_srcmac_addr = '0;
        arp.i_arp_srcip_addr  = '0;

        // Reset state
        tick(3);
        chk("rst_tx_en",   64'(arp.o_arp_tx_en),       64'd0);
        chk("rst_tx_type", 64'(arp.o_arp_tx_type),     64'd0);
        chk("rst_desmac",  64'(arp.o_arp_desmac_addr), 64'd0);
        chk("rst_desip",   64'(arp.o_arp_desip_addr),  64'd0);
        chk("rst_busy",    64'(busy),                  64'd0);
        chk("rst_pvalid",  64'(peer_valid),            64'd0);
        chk("rst_done",    64'(resolve_done),          64'd0);
        chk("rst_fail",    64'(resolve_fail),          64'd0);
        rst_n = 1'b1;
        tick(3);

        // Incoming requests: reply two cycles after rx_done; back-to-back pairs give two replies.
        for (int i = 0; i < 6; i++) begin
            mac  = (i == 0) ? 48'h0a_0b_0c_0d_0e_0f : {16'($urandom), $urandom};
            ip   = (i == 0) ? 32'hc0a8_0166 : $urandom;
            base = frames.size();
            send_rx(ARP_OP_REQ, mac, ip, c);
            if (i % 2 == 1) begin
                mac2 = {16'($urandom), $urandom};
                ip2  = $urandom;
                send_rx(ARP_OP_REQ, mac2, ip2, c2);
                wait_frames(base + 2, 60, "rpl2_seen");
                chk_frame("rpl_a", base, c + 2, ARP_OP_RPL, mac, ip);
                if (dones.size() > base)
                    chk_frame("rpl_b", base + 1, dones[base] + 2, ARP_OP_RPL, mac2, ip2);
            end else begin
                wait_frames(base + 1, 30, "rpl_seen");
                chk_frame("rpl", base, c + 2, ARP_OP_RPL, mac, ip);
            end
            wait_idle(60, "rpl_idle");
            b = frames.size();
            send_rx(ARP_OP_RPL, {16'($urandom), $urandom}, $urandom, c);
            tick(12);
            chk("stray_reply_nofrm", 64'(frames.size()), 64'(b));
            chk("stray_reply_pvalid", 64'(peer_valid), 64'd0);
        end

        // Resolve with a reply 500 cycles after the request went out.
        pip  = 32'hc0a8_0166;
        pmac = {16'($urandom), $urandom};
        base = frames.size(); d0 = n_done; f0 = n_fail;
        resolve(pip, c);
        wait_frames(base + 1, 20, "res_req_seen");
        chk_frame("res_req", base, c + 1, ARP_OP_REQ, ARP_BCAST_MAC, pip);
        wait_dones(base + 1, 40, "res_req_done");
        tick(500);
        send_rx(ARP_OP_RPL, pmac, pip, c);
        tick(5);
        chk("res_done_cnt", 64'(n_done - d0), 64'd1);
        chk("res_fail_cnt", 64'(n_fail - f0), 64'd0);
        chk("res_pvalid",   64'(peer_valid),  64'd1);
        chk("res_pmac",     64'(peer_mac),    64'(pmac));
        chk("res_pip",      64'(peer_ip),     64'(pip));
        chk("res_noretry",  64'(frames.size()), 64'(base + 1));
        chk("res_idle",     64'(busy),        64'd0);

        // Reset while a reply is being sent, then a fresh resolve.
        base = frames.size();
        send_rx(ARP_OP_REQ, {16'($urandom), $urandom}, $urandom, c);
        wait_frames(base + 1, 20, "rstrpl_seen");
        chk("rstrpl_busy", 64'(busy), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("rstrpl_tx_en",  64'(arp.o_arp_tx_en),       64'd0);
        chk("rstrpl_type",   64'(arp.o_arp_tx_type),     64'd0);
        chk("rstrpl_desmac", 64'(arp.o_arp_desmac_addr), 64'd0);
        chk("rstrpl_desip",  64'(arp.o_arp_desip_addr),  64'd0);
        chk("rstrpl_busy0",  64'(busy),                  64'd0);
        chk("rstrpl_pvalid", 64'(peer_valid),            64'd0);
        chk("rstrpl_pmac",   64'(peer_mac),              64'd0);
        tick(2);
        rst_n = 1'b1;
        tick(16);
        pip  = $urandom;
        pmac = {16'($urandom), $urandom};
        base = frames.size(); d0 = n_done;
        resolve(pip, c);
        wait_frames(base + 1, 20, "post_rst_seen");
        chk_frame("post_rst_req", base, c + 1, ARP_OP_REQ, ARP_BCAST_MAC, pip);
        wait_dones(base + 1, 40, "post_rst_done");
        send_rx(ARP_OP_RPL, pmac, pip, c);
        tick(4);
        chk("post_rst_done_cnt", 64'(n_done - d0), 64'd1);
        chk("post_rst_pmac",     64'(peer_mac),    64'(pmac));

        // No reply: first request plus MAXR retries, each R cycles after the previous tx_done, then fail.
        pip  = $urandom;
        base = frames.size(); d0 = n_done; f0 = n_fail;
        resolve(pip, c);
        b = (MAXR + 1) * (R + 40) + 100;
        while (n_fail == f0 && b > 0) begin
            @(posedge clk); #1;
            b--;
        end
        chk("nr_fail_seen", 64'(n_fail - f0), 64'd1);
        chk("nr_frames", 64'(frames.size() - base), 64'(MAXR + 1));
        chk_frame("nr_req0", base, c + 1, ARP_OP_REQ, ARP_BCAST_MAC, pip);
        for (int j = 1; j <= int'(MAXR); j++) begin
            if (dones.size() > base + j - 1)
                chk_frame($sformatf("nr_req%0d", j), base + j, dones[base + j - 1] + 1 + R,
                          ARP_OP_REQ, ARP_BCAST_MAC, pip);
        end
        if (dones.size() > base + MAXR)
            chk("nr_fail_cyc", 64'(fail_cyc), 64'(dones[base + MAXR] + 1 + R));
        tick(3);
        chk("nr_fail_once", 64'(n_fail - f0), 64'd1);
        chk("nr_no_done",   64'(n_done - d0), 64'd0);
        chk("nr_pvalid",    64'(peer_valid),  64'd0);
        chk("nr_idle",      64'(busy),        64'd0);

        // Request lands mid-wait: timer freezes across the reply and resumes where it stopped.
        pip  = $urandom;
        pmac = {16'($urandom), $urandom};
        base = frames.size(); d0 = n_done;
        resolve(pip, c);
        wait_dones(base + 1, 40, "fz_req_done");
        d = (dones.size() > base) ? dones[base] : 0;
        k = $urandom_range(20, 300);
        tick(k);
        mac = {16'($urandom), $urandom};
        ip  = $urandom;
        send_rx(ARP_OP_REQ, mac, ip, n);
        wait_frames(base + 2, 20, "fz_rpl_seen");
        chk_frame("fz_rpl", base + 1, n + 2, ARP_OP_RPL, mac, ip);
        wait_dones(base + 2, 40, "fz_rpl_done");
        t = (dones.size() > base + 1) ? dones[base + 1] : 0;
        wait_frames(base + 3, R + 60, "fz_retry_seen");
        // Timer had counted n-d cycles; R-(n-d) remain after the return edge t+1.
        chk_frame("fz_retry", base + 2, (t + 1) + R - (n - d), ARP_OP_REQ, ARP_BCAST_MAC, pip);
        wait_dones(base + 3, 40, "fz_retry_done");
        send_rx(ARP_OP_RPL, pmac, pip, c);
        tick(4);
        chk("fz_done_cnt", 64'(n_done - d0), 64'd1);
        chk("fz_pvalid",   64'(peer_valid),  64'd1);
        chk("fz_pmac",     64'(peer_mac),    64'(pmac));

        // Two requests while the broadcast is going out: one reply, to the second requester.
        pip  = $urandom;
        pmac = {16'($urandom), $urandom};
        base = frames.size(); d0 = n_done;
        resolve(pip, c);
        send_rx(ARP_OP_REQ, {16'($urandom), $urandom}, $urandom, c2);
        mac2 = {16'($urandom), $urandom};
        ip2  = $urandom;
        send_rx(ARP_OP_REQ, mac2, ip2, c2);
        wait_frames(base + 2, 40, "two_rpl_seen");
        if (dones.size() > base)
            chk_frame("two_rpl", base + 1, dones[base] + 2, ARP_OP_RPL, mac2, ip2);
        wait_dones(base + 2, 40, "two_rpl_done");
        send_rx(ARP_OP_RPL, pmac, pip, c);
        tick(4);
        chk("two_one_reply", 64'(frames.size()), 64'(base + 2));
        chk("two_done_cnt",  64'(n_done - d0),   64'd1);
        chk("two_pmac",      64'(peer_mac),      64'(pmac));
        chk("two_idle",      64'(busy),          64'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/arp_ctrl.md
# arp_ctrl

Sequencing controller for the ARP engine (receiver plus transmitter with CRC). It answers every ARP request addressed to the board with a reply. It also resolves one target IP on user demand, using broadcast requests with timed retries, and caches the learned peer MAC/IP for the UDP path. It sits between the ARP engine's user port and the top-level Ethernet control logic, in the GMII transmit clock domain; receive-side status inputs are already synchronous to that clock.

## Interface
- RETRY_CYCLES, 32'd125_000_000: cycles to wait for a reply before re-requesting (1 s at 125 MHz); must be ≥ 2.
- MAX_RETRY, 4'd3: re-requests after the first request before failing.
- i_gmii_tx_clk  in  1  sole clock.
- i_rst_n  in  1  asynchronous, active-low reset.
- i_arp_rx_done  in  1  one-cycle pulse, ARP frame received for board IP.
- i_arp_rx_type  in  1  0 request, 1 reply; valid with i_arp_rx_done.
- i_arp_srcmac_addr  in  48  sender MAC; valid with i_arp_rx_done.
- i_arp_srcip_addr  in  32  sender IP; valid with i_arp_rx_done.
- o_arp_tx_en  out  1  one-cycle transmit start pulse.
- o_arp_tx_type  out  1  0 request, 1 reply; held from o_arp_tx_en until i_arp_tx_done.
- o_arp_desmac_addr  out  48  destination MAC; held like o_arp_tx_type.
- o_arp_desip_addr  out  32  destination IP; held like o_arp_tx_type.
- i_arp_tx_done  in  1  one-cycle pulse, frame fully sent.
- i_resolve_req  in  1  pulse, start resolving i_resolve_ip; accepted only while o_busy=0.
- i_resolve_ip  in  32  target IP; sampled with accepted i_resolve_req.
- o_busy  out  1  state≠IDLE or a reply is pending.
- o_peer_valid  out  1  cache holds a resolved MAC for o_peer_ip.
- o_peer_mac  out  48  cached MAC.
- o_peer_ip  out  32  target IP (cache key).
- o_resolve_done  out  1  one-cycle pulse, resolution succeeded.
- o_resolve_fail  out  1  one-cycle pulse, retries exhausted.

## Operation
- States: IDLE, REQ_TX, WAIT_REPLY, RPL_TX. Flag `resolving` selects where RPL_TX returns (WAIT_REPLY if 1, else IDLE).
- Receiving a request (rx_done, type 0):
  - Latch srcmac/srcip into the pending-reply registers and set pend_reply.
  - A second request before service overwrites the first (newest wins, one reply only).
- Any received frame (request or reply) whose srcip equals o_peer_ip while `resolving`=1 or o_peer_valid=1:
  - Writes srcmac into o_peer_mac and sets o_peer_valid.
- IDLE:
  - If pend_reply: go to RPL_TX, pulse tx_en with type 1 and the latched dest MAC/IP, clear pend_reply.
  - Else, on i_resolve_req: set o_peer_ip=i_resolve_ip, clear o_peer_valid, retry=0, set `resolving`; go to REQ_TX, pulse tx_en with type 0, desmac ff_ff_ff_ff_ff_ff, desip o_peer_ip.
- REQ_TX: on tx_done, clear timer and go to WAIT_REPLY.
- WAIT_REPLY (checks in priority order):
  - Reply (type 1) from o_peer_ip: pulse o_resolve_done, clear `resolving`, go to IDLE. A same-cycle timer expiry is ignored.
  - Else, if pend_reply: go to RPL_TX. The timer is frozen, not cleared.
  - Else the timer increments. At RETRY_CYCLES−1:
    - If retry<MAX_RETRY: retry+1, go to REQ_TX and re-send the request.
    - Else: pulse o_resolve_fail, clear `resolving`, go to IDLE; o_peer_valid stays 0.
- RPL_TX: on tx_done, go to the return state. Requests arriving meanwhile are latched as pending.
- Success from a request frame: the cache update sets o_peer_valid while `resolving`. The next WAIT_REPLY cycle sees o_peer_valid=1, pulses o_resolve_done and goes to IDLE.
- No tx_done watchdog: the controller waits indefinitely in REQ_TX/RPL_TX.

## Timing
- Reset: all outputs 0, desmac/desip 0, state IDLE, pend_reply 0, counters 0.
- Outputs are registered. i_resolve_req at edge k gives o_arp_tx_en=1 in cycle k+1, with dest fields valid the same cycle.
- A request received with rx_done at edge k, controller IDLE: tx_en in cycle k+2 (latch, then issue).
- Retry interval: exactly RETRY_CYCLES cycles from the WAIT_REPLY entry edge to the next tx_en, excluding frozen cycles.
- rx_done and tx_done in the same cycle are both processed.
- Reset mid-transmit drops o_arp_tx_en and clears the cache; the ARP engine is reset by the same i_rst_n.

## Structure
- Package arp_pkg holds:
  - state encoding;
  - ARP_BCAST_MAC=48'hff_ff_ff_ff_ff_ff;
  - ARP_OP_REQ=1'b0, ARP_OP_RPL=1'b1.
- Natural sub-module: arp_retry_timer, a 32-bit counter with clear, freeze and an expiry compare.
- The remaining logic is one FSM plus the cache and pending-reply registers.

## Test plan
- Request from 192.168.1.102 / MAC 0a_0b_0c_0d_0e_0f, controller IDLE -> tx_en two cycles later with type 1, desmac 0a_0b_0c_0d_0e_0f, desip c0a80166.
- resolve_req ip c0a80166; reply returns 500 cycles after tx_done -> o_peer_valid=1, o_peer_mac=reply MAC, single o_resolve_done pulse, no retry.
- resolve_req with no reply, RETRY_CYCLES=100, MAX_RETRY=3 -> 4 broadcast requests 100 cycles apart, then o_resolve_fail, o_peer_valid=0.
- Request arrives during WAIT_REPLY at timer=40 -> reply sent; timer resumes at 40; retry occurs 60 WAIT_REPLY cycles after return.
- Two requests arrive during REQ_TX -> exactly one reply, addressed to the second requester.
- i_rst_n asserted during RPL_TX -> all outputs 0 immediately; i_resolve_req after release is accepted.
